// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: state encoding and
// default sizing of the performance counters and memory-stall timeout.
package pipeline_ctrl_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned TIMER_W     = 8;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StError   = 2'b10
    } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: combinational stage enables,
// memory-stall watchdog FSM and saturating stall/flush performance counters.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             clr_counters,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       ctrl_state
);

    localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(TIMEOUT - 1);

    logic [1:0]         state_q;
    logic [TIMER_W-1:0] timer_q;
    logic               mem_timeout_q;
    logic               mem_stall;
    logic               in_error;
    logic               branch_flush;
    logic               stall_inc;

    assign mem_stall = dmem_req & ~dmem_ready;
    // Bit 1 set covers both StError and the unused 2'b11 encoding.
    assign in_error  = state_q[1];

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst || in_error) begin
            // everything frozen
        end else if (mem_stall) begin
            mem_wb_write = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            mem_wb_write = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (hazard_detected) begin
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            mem_wb_write = 1'b1;
            id_ex_flush  = 1'b1;
        end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            mem_wb_write = 1'b1;
        end
    end

    assign branch_flush = ~rst & ~in_error & ~mem_stall & branch_taken;
    assign stall_inc    = ~rst & ~in_error & ~pc_write;

    // Timer holds the number of consecutive stall cycles already completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            timer_q       <= '0;
            mem_timeout_q <= 1'b0;
        end else if (!in_error) begin
            if (mem_stall) begin
                if (timer_q == TimerLast) begin
                    state_q       <= StError;
                    timer_q       <= '0;
                    mem_timeout_q <= 1'b1;
                end else begin
                    state_q <= StMemWait;
                    timer_q <= timer_q + TIMER_W'(1);
                end
            end else begin
                state_q <= StRun;
                timer_q <= '0;
            end
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign ctrl_state  = state_q;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .clr   (clr_counters),
        .count (stall_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_flush),
        .clr   (clr_counters),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench: two controller instances (default sizing and a small
// CNT_W=4 / TIMEOUT=4 one) share stimulus and are checked against a model.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hazard_detected = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0;
    logic dmem_ready = 1'b0, clr_counters = 1'b0;

    always #5 clk = ~clk;

    logic        a_pc, a_ifid_w, a_idex_w, a_exmem_w, a_memwb_w;
    logic        a_ifid_f, a_idex_f, a_exmem_f, a_memwb_f, a_to;
    logic [15:0] a_sc, a_fc;
    logic [1:0]  a_st;
    logic        b_pc, b_ifid_w, b_idex_w, b_exmem_w, b_memwb_w;
    logic        b_ifid_f, b_idex_f, b_exmem_f, b_memwb_f, b_to;
    logic [3:0]  b_sc, b_fc;
    logic [1:0]  b_st;

    pipeline_stall_ctrl #(.CNT_W(16), .TIMEOUT(255)) dut_a (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .clr_counters(clr_counters),
        .pc_write(a_pc), .if_id_write(a_ifid_w), .id_ex_write(a_idex_w),
        .ex_mem_write(a_exmem_w), .mem_wb_write(a_memwb_w), .if_id_flush(a_ifid_f),
        .id_ex_flush(a_idex_f), .ex_mem_flush(a_exmem_f), .mem_wb_flush(a_memwb_f),
        .mem_timeout(a_to), .stall_count(a_sc), .flush_count(a_fc), .ctrl_state(a_st)
    );

    pipeline_stall_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .clr_counters(clr_counters),
        .pc_write(b_pc), .if_id_write(b_ifid_w), .id_ex_write(b_idex_w),
        .ex_mem_write(b_exmem_w), .mem_wb_write(b_memwb_w), .if_id_flush(b_ifid_f),
        .id_ex_flush(b_idex_f), .ex_mem_flush(b_exmem_f), .mem_wb_flush(b_memwb_f),
        .mem_timeout(b_to), .stall_count(b_sc), .flush_count(b_fc), .ctrl_state(b_st)
    );

    // Control vector: {pc, if_id, id_ex, ex_mem, mem_wb writes, if_id..mem_wb flushes}
    logic [8:0]  d_ctrl [2];
    logic [1:0]  d_st   [2];
    logic        d_to   [2];
    logic [15:0] d_sc   [2];
    logic [15:0] d_fc   [2];

    assign d_ctrl[0] = {a_pc, a_ifid_w, a_idex_w, a_exmem_w, a_memwb_w,
                        a_ifid_f, a_idex_f, a_exmem_f, a_memwb_f};
    assign d_ctrl[1] = {b_pc, b_ifid_w, b_idex_w, b_exmem_w, b_memwb_w,
                        b_ifid_f, b_idex_f, b_exmem_f, b_memwb_f};
    assign d_st[0] = a_st;
    assign d_st[1] = b_st;
    assign d_to[0] = a_to;
    assign d_to[1] = b_to;
    assign d_sc[0] = a_sc;
    assign d_sc[1] = {12'd0, b_sc};
    assign d_fc[0] = a_fc;
    assign d_fc[1] = {12'd0, b_fc};

    localparam logic [8:0] CtrlOff    = 9'b00000_0000;
    localparam logic [8:0] CtrlMem    = 9'b00001_0001;
    localparam logic [8:0] CtrlBranch = 9'b11111_1110;
    localparam logic [8:0] CtrlHazard = 9'b00111_0100;
    localparam logic [8:0] CtrlNormal = 9'b11111_0000;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [8:0] exp_ctrl(input bit err, input bit r, input bit h,
                                            input bit b, input bit q, input bit y);
        if (r || err)  return CtrlOff;
        if (q && !y)   return CtrlMem;
        if (b)         return CtrlBranch;
        if (h)         return CtrlHazard;
        return CtrlNormal;
    endfunction

    // Behavioural model: error flag, consecutive stall run length, counters.
    int unsigned to_lim [2] = '{255, 4};
    int unsigned cmax   [2] = '{65535, 15};
    bit          m_err  [2];
    bit          m_to   [2];
    int unsigned m_run  [2];
    int unsigned m_sc   [2];
    int unsigned m_fc   [2];
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_err[k] = 1'b0; m_to[k] = 1'b0; m_run[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            end else if (model_valid) begin
                logic [8:0] c;
                c = exp_ctrl(m_err[k], 1'b0, hazard_detected, branch_taken, dmem_req, dmem_ready);
                if (clr_counters) begin
                    m_sc[k] = 0;
                    m_fc[k] = 0;
                end else begin
                    if (!m_err[k] && !c[8] && m_sc[k] < cmax[k]) m_sc[k]++;
                    if (!m_err[k] && c == CtrlBranch && m_fc[k] < cmax[k]) m_fc[k]++;
                end
                if (!m_err[k]) begin
                    if (dmem_req && !dmem_ready) begin
                        m_run[k]++;
                        if (m_run[k] == to_lim[k]) begin
                            m_err[k] = 1'b1;
                            m_to[k]  = 1'b1;
                            m_run[k] = 0;
                        end
                    end else begin
                        m_run[k] = 0;
                    end
                end
            end
        end
        if (rst) model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int k = 0; k < 2; k++) begin
                logic [1:0] es;
                es = m_err[k] ? 2'd2 : (m_run[k] > 0 ? 2'd1 : 2'd0);
                chk($sformatf("ctrl[%0d]", k), 32'(d_ctrl[k]),
                    32'(exp_ctrl(m_err[k], rst, hazard_detected, branch_taken,
                                 dmem_req, dmem_ready)));
                chk($sformatf("state[%0d]", k), 32'(d_st[k]), 32'(es));
                chk($sformatf("timeout[%0d]", k), 32'(d_to[k]), 32'(m_to[k]));
                chk($sformatf("stall_count[%0d]", k), 32'(d_sc[k]), m_sc[k]);
                chk($sformatf("flush_count[%0d]", k), 32'(d_fc[k]), m_fc[k]);
            end
        end
    end

    // Apply one cycle of inputs just after the edge; return at the sampling edge.
    task automatic cyc(input bit h, input bit b, input bit q, input bit y,
                       input bit c, input bit r);
        @(posedge clk);
        #2;
        hazard_detected = h; branch_taken = b; dmem_req = q;
        dmem_ready = y; clr_counters = c; rst = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        chk("rst_ctrl_off_a", 32'(d_ctrl[0]), 32'(CtrlOff));
        cyc(0, 0, 0, 0, 0, 0);
        chk("reset_state", 32'(a_st), 32'd0);
        chk("reset_stall_count", 32'(a_sc), 32'd0);
        chk("reset_timeout", 32'(a_to), 32'd0);

        // Single hazard cycle
        cyc(1, 0, 0, 0, 0, 0);
        chk("hazard_ctrl", 32'(d_ctrl[0]), 32'(CtrlHazard));
        cyc(0, 0, 0, 0, 0, 0);
        chk("hazard_stall_count", 32'(a_sc), 32'd1);

        // Three-cycle memory stall
        do_reset();
        cyc(0, 0, 1, 0, 0, 0);
        chk("memstall_ctrl", 32'(d_ctrl[0]), 32'(CtrlMem));
        chk("memstall_first_state", 32'(a_st), 32'd0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("memwait_state", 32'(a_st), 32'd1);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        chk("mem_ready_ctrl", 32'(d_ctrl[0]), 32'(CtrlNormal));
        cyc(0, 0, 0, 0, 0, 0);
        chk("mem_back_run", 32'(a_st), 32'd0);
        chk("mem_stall_count", 32'(a_sc), 32'd3);

        // Branch beats hazard
        cyc(1, 1, 0, 0, 0, 0);
        chk("branch_ctrl", 32'(d_ctrl[0]), 32'(CtrlBranch));
        cyc(0, 0, 0, 0, 0, 0);
        chk("branch_flush_count", 32'(a_fc), 32'd1);
        chk("branch_stall_count", 32'(a_sc), 32'd3);

        // Timeout on the small instance
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("pre_timeout_state", 32'(b_st), 32'd1);
        chk("pre_timeout_flag", 32'(b_to), 32'd0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("timeout_state", 32'(b_st), 32'd2);
        chk("timeout_flag", 32'(b_to), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("error_ctrl_off", 32'(d_ctrl[1]), 32'(CtrlOff));

        // Ready on the would-be timeout cycle cancels it
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("cancel_state", 32'(b_st), 32'd0);
        chk("cancel_flag", 32'(b_to), 32'd0);

        // Saturation and clear priority with CNT_W=4
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        chk("sat_stall_count", 32'(b_sc), 32'd15);
        cyc(0, 0, 0, 0, 0, 0);
        chk("clr_stall_count", 32'(b_sc), 32'd0);

        // Reset mid MEM_WAIT leaves no residual timer
        do_reset();
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("pre_rst_memwait", 32'(b_st), 32'd1);
        cyc(0, 0, 1, 0, 0, 1);
        chk("rst_ctrl_off_b", 32'(d_ctrl[1]), 32'(CtrlOff));
        cyc(0, 0, 0, 0, 0, 0);
        chk("post_rst_state", 32'(b_st), 32'd0);
        chk("post_rst_stall_count", 32'(a_sc), 32'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("no_residual_timer", 32'(b_st), 32'd1);
        cyc(0, 0, 1, 0, 0, 0);
        chk("full_timeout_after_rst", 32'(b_st), 32'd2);

        // Randomized traffic with occasional stall-heavy bursts
        for (int blk = 0; blk < 80; blk++) begin
            int unsigned heavy;
            heavy = $urandom_range(0, 2);
            for (int i = 0; i < 50; i++) begin
                bit q, y;
                q = (heavy == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
                y = (heavy == 0) ? ($urandom_range(0, 7) == 0) : $urandom_range(0, 1);
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, q, y,
                    $urandom_range(0, 60) == 0, $urandom_range(0, 120) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter CNT_W, 16, width of the performance counters.
REQ-002 Parameter TIMEOUT, 255, maximum consecutive memory-stall cycles before error (legal range 2..255).
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 hazard_detected  in  1  load-use hazard from the hazard detection unit.
REQ-006 branch_taken  in  1  taken branch resolved in MEM stage.
REQ-007 dmem_req  in  1  MEM-stage instruction accesses data memory.
REQ-008 dmem_ready  in  1  data memory completes access this cycle.
REQ-009 clr_counters  in  1  synchronous clear of both counters.
REQ-010 pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  stage-register write enables.
REQ-011 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  insert bubble into the stage register.
REQ-012 mem_timeout  out  1  sticky memory-timeout error.
REQ-013 stall_count, flush_count  out  CNT_W each  saturating performance counters.
REQ-014 ctrl_state  out  2  current FSM state (debug).

Function
REQ-015 States: RUN (2'b00), MEM_WAIT (2'b01), ERROR (2'b10); encoding 2'b11 shall be treated as ERROR.
REQ-016 mem_stall = dmem_req AND NOT dmem_ready; all control outputs are combinational from state and inputs (zero latency).
REQ-017 Priority, highest first: ERROR, mem_stall, branch_taken, hazard_detected, normal.
REQ-018 ERROR: all write enables 0, all flushes 0.
REQ-019 mem_stall (RUN or MEM_WAIT): pc/if_id/id_ex/ex_mem writes 0, mem_wb_write 1, mem_wb_flush 1, other flushes 0.
REQ-020 branch_taken: all writes 1; if_id_flush, id_ex_flush, ex_mem_flush 1; mem_wb_flush 0.
REQ-021 hazard_detected: pc_write 0, if_id_write 0, id_ex_flush 1; other writes 1, other flushes 0.
REQ-022 Normal: all writes 1, all flushes 0.
REQ-023 RUN -> MEM_WAIT on mem_stall; MEM_WAIT -> RUN when NOT mem_stall; ERROR exits only on rst.
REQ-024 Stall timer counts consecutive mem_stall cycles (first counted cycle in RUN); cleared whenever mem_stall is 0.
REQ-025 On the edge ending the TIMEOUT-th consecutive mem_stall cycle, state -> ERROR and mem_timeout -> 1; dmem_ready on that same cycle cancels the transition.
REQ-026 stall_count increments each cycle pc_write is 0 outside ERROR; flush_count increments each cycle branch flush (REQ-020) is applied.
REQ-027 Counters saturate at all-ones; clr_counters takes priority over increment in the same cycle.

Reset
REQ-028 rst sampled high: state RUN, stall timer 0, stall_count 0, flush_count 0, mem_timeout 0 on the next edge.
REQ-029 While rst is high, all write enables 0 and all flushes 0, regardless of state.
REQ-030 rst asserted mid-MEM_WAIT or in ERROR shall return to RUN with no residual timer count.

Structure
REQ-031 Package pipeline_ctrl_pkg holds the state encoding constants and CNT_W/TIMEOUT defaults.
REQ-032 One sub-module, sat_counter (parameter width; inc, clr inputs), is instantiated twice for the counters.

Verification
REQ-033 hazard_detected=1 one cycle in RUN -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_count 0->1.
REQ-034 dmem_req=1, dmem_ready=0 for 3 cycles then ready=1 -> 3 freeze cycles, MEM_WAIT entered after first edge, RUN after ready; stall_count=3.
REQ-035 branch_taken=1 and hazard_detected=1 same cycle -> branch flush outputs, pc_write=1; flush_count+1, stall_count unchanged.
REQ-036 TIMEOUT=4, dmem_req=1, dmem_ready=0 held -> ERROR and mem_timeout=1 after 4th edge; all enables 0 until rst.
REQ-037 stall_count preset near all-ones via CNT_W=4 with 20 hazard cycles -> holds at 15; clr_counters with hazard same cycle -> 0.
REQ-038 rst asserted during MEM_WAIT -> next cycle ctrl_state=RUN, timer 0, counters 0; outputs 0 while rst high.
